// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: shared FSM encodings and default sizes for the RAM-backed FIFO controller.
// Rev 1.0
`default_nettype none

package ram_fifo_ctrl_pkg;

   localparam int unsigned c_DEFAULT_DATA_WIDTH    = 8;
   localparam int unsigned c_DEFAULT_ADDRESS_WIDTH = 10;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_e;

endpackage : ram_fifo_ctrl_pkg

`default_nettype wire

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr: wrapping RAM address pointer with synchronous active-high reset.
// Rev 1.0
`default_nettype none

module ram_fifo_ptr #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] ptr_o
);

   logic [WIDTH-1:0] ptr_q;
   logic [WIDTH-1:0] ptr_d;

   // Depth is a power of two, so the natural modulo wrap takes depth-1 back to 0.
   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) begin
         ptr_d = ptr_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule : ram_fifo_ptr

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller over an external single-port RAM with a one-word output register.
// Rev 1.0 -- define RAM_FIFO_CTRL_ERR_EN to add the sticky overflow flag o_w_err.
`default_nettype none

module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int unsigned p_data_width    = c_DEFAULT_DATA_WIDTH,
   parameter int unsigned p_address_width = c_DEFAULT_ADDRESS_WIDTH
) (
   input  logic                       i_w_clk,
   input  logic                       i_w_reset,
   input  logic                       i_w_push,
   input  logic [p_data_width-1:0]    i_w_push_data,
   output logic                       o_w_push_ready,
   output logic                       o_w_pop_valid,
   output logic [p_data_width-1:0]    o_w_pop_data,
   input  logic                       i_w_pop_ready,
   output logic [p_address_width-1:0] o_w_mem_address,
   output logic [p_data_width-1:0]    o_w_mem_in,
   output logic                       o_w_mem_oe,
   output logic                       o_w_mem_we,
   input  logic [p_data_width-1:0]    i_w_mem_out,
   output logic [p_address_width:0]   o_w_count
`ifdef RAM_FIFO_CTRL_ERR_EN
   ,
   output logic                       o_w_err
`endif
);

   localparam logic [p_address_width:0] c_DEPTH_CNT = {1'b1, {p_address_width{1'b0}}};
   localparam logic [p_address_width:0] c_ONE       = {{p_address_width{1'b0}}, 1'b1};

   state_e                      state_q, state_d;
   logic [p_address_width:0]    mem_count_q, mem_count_d;
   logic                        pop_valid_q, pop_valid_d;
   logic [p_data_width-1:0]     pop_data_q, pop_data_d;
   logic [p_address_width-1:0]  addr_q, addr_d;
   logic [p_data_width-1:0]     mem_in_q, mem_in_d;

   logic [p_address_width-1:0]  wr_ptr;
   logic [p_address_width-1:0]  rd_ptr;
   logic                        read_needed;
   logic                        push_ready;
   logic                        push_fire;
   logic                        pop_fire;
   logic                        mem_we;
   logic                        mem_oe;
   logic                        rd_inc;

   assign read_needed = (state_q == IDLE) && !pop_valid_q && (mem_count_q != '0);
   assign push_ready  = (state_q == IDLE) && (mem_count_q < c_DEPTH_CNT) && !read_needed;
   assign push_fire   = i_w_push && push_ready;
   assign pop_fire    = pop_valid_q && i_w_pop_ready;
   assign rd_inc      = (state_q == RD_WAIT);

   ram_fifo_ptr #(
      .WIDTH (p_address_width)
   ) u_wr_ptr (
      .clk_i (i_w_clk),
      .rst_i (i_w_reset),
      .inc_i (push_fire),
      .ptr_o (wr_ptr)
   );

   ram_fifo_ptr #(
      .WIDTH (p_address_width)
   ) u_rd_ptr (
      .clk_i (i_w_clk),
      .rst_i (i_w_reset),
      .inc_i (rd_inc),
      .ptr_o (rd_ptr)
   );

   // Refilling the empty output register wins over a push; push_ready already excludes it.
   always_comb begin
      state_d     = state_q;
      mem_count_d = mem_count_q;
      pop_valid_d = pop_valid_q;
      pop_data_d  = pop_data_q;
      addr_d      = addr_q;
      mem_in_d    = mem_in_q;
      mem_we      = 1'b0;
      mem_oe      = 1'b0;

      if (pop_fire) begin
         pop_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (read_needed) begin
               mem_oe  = 1'b1;
               addr_d  = rd_ptr;
               state_d = RD_WAIT;
            end else if (push_fire) begin
               mem_we      = 1'b1;
               addr_d      = wr_ptr;
               mem_in_d    = i_w_push_data;
               mem_count_d = mem_count_q + c_ONE;
            end
         end
         RD_WAIT: begin
            mem_oe      = 1'b1;
            pop_data_d  = i_w_mem_out;
            pop_valid_d = 1'b1;
            mem_count_d = mem_count_q - c_ONE;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_w_clk) begin
      if (i_w_reset) begin
         state_q     <= IDLE;
         mem_count_q <= '0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
         addr_q      <= '0;
         mem_in_q    <= '0;
      end else begin
         state_q     <= state_d;
         mem_count_q <= mem_count_d;
         pop_valid_q <= pop_valid_d;
         pop_data_q  <= pop_data_d;
         addr_q      <= addr_d;
         mem_in_q    <= mem_in_d;
      end
   end

   // Strobes are masked during reset so an aborted cycle never reaches the RAM.
   assign o_w_mem_we      = mem_we & ~i_w_reset;
   assign o_w_mem_oe      = mem_oe & ~i_w_reset;
   assign o_w_mem_address = addr_d;
   assign o_w_mem_in      = mem_in_d;
   assign o_w_push_ready  = push_ready;
   assign o_w_pop_valid   = pop_valid_q;
   assign o_w_pop_data    = pop_data_q;
   assign o_w_count       = mem_count_q + {{p_address_width{1'b0}}, pop_valid_q};

`ifdef RAM_FIFO_CTRL_ERR_EN
   logic err_q;

   always_ff @(posedge i_w_clk) begin
      if (i_w_reset) begin
         err_q <= 1'b0;
      end else if (i_w_push && (mem_count_q == c_DEPTH_CNT)) begin
         err_q <= 1'b1;
      end
   end

   assign o_w_err = err_q;
`endif

endmodule : ram_fifo_ctrl

`default_nettype wire
